// File: rtl/idelay_ctrl_seq.sv
// idelay_ctrl_seq
// -----------------------------------------------------------------------------
// Bring-up sequencer for an IDELAYCTRL instance. It sits in the IDELAYCTRL
// reference-clock domain and does the following:
//   - drives a calibration reset of fixed width;
//   - waits, with a timeout, for RDY to come back;
//   - retries a bounded number of times;
//   - reports ready / fail status.
// The sequence runs again when RDY is lost while ready, or when a restart is
// requested.
//
// Ports:
//   refclk    in   IDELAYCTRL reference clock (only clock)
//   rst_n     in   asynchronous active-low reset
//   restart   in   single-cycle request to re-run calibration from any state
//   rdy       in   IDELAYCTRL RDY (asynchronous, synchronized internally)
//   idc_rst   out  reset to IDELAYCTRL, active high
//   ready     out  calibration complete and RDY currently held
//   busy      out  sequencer in RST or WAIT
//   fail      out  retries exhausted (sticky until restart / rst_n)
//   rdy_lost  out  one-cycle pulse when RDY drops while ready
//   retry_cnt out  retries consumed in the current sequence
// -----------------------------------------------------------------------------
module idelay_ctrl_seq #(
  parameter int RST_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_WIDTH      = 16,
  parameter int RETRY_WIDTH    = 2
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  input  logic                   restart,
  input  logic                   rdy,
  output logic                   idc_rst,
  output logic                   ready,
  output logic                   busy,
  output logic                   fail,
  output logic                   rdy_lost,
  output logic [RETRY_WIDTH-1:0] retry_cnt
);

  localparam logic [CNT_WIDTH-1:0]   RST_LAST  = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   STALE_CNT = CNT_WIDTH'(3);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [RETRY_WIDTH-1:0] RETRY_MAX = RETRY_WIDTH'(MAX_RETRIES);
  localparam logic [RETRY_WIDTH-1:0] RETRY_ONE = RETRY_WIDTH'(1);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  state_t                 state_q,     state_d;
  logic [CNT_WIDTH-1:0]   cnt_q,       cnt_d;
  logic [RETRY_WIDTH-1:0] retry_cnt_q, retry_cnt_d;
  logic                   rdy_lost_q,  rdy_lost_d;
  logic                   rdy_meta_q;
  logic                   rdy_s_q;
  logic                   idc_rst_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   fail_q;

  // Next-state / counter logic. restart overrides every other transition,
  // including a coincident RDY drop, which is why it is tested first.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_cnt_d = retry_cnt_q;
    rdy_lost_d  = 1'b0;

    if (restart) begin
      state_d     = S_RST;
      cnt_d       = '0;
      retry_cnt_d = '0;
    end else begin
      case (state_q)
        S_RST: begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end

        S_WAIT: begin
          cnt_d = cnt_q + CNT_ONE;
          // The first three WAIT cycles ignore rdy_s. This lets any RDY level
          // left over from before the reset drain out of the synchronizer.
          if ((cnt_q >= STALE_CNT) && rdy_s_q) begin
            state_d = S_READY;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (retry_cnt_q < RETRY_MAX) begin
              retry_cnt_d = retry_cnt_q + RETRY_ONE;
              state_d     = S_RST;
            end else begin
              state_d = S_FAIL;
            end
          end
        end

        S_READY: begin
          cnt_d = '0;
          if (!rdy_s_q) begin
            rdy_lost_d  = 1'b1;
            retry_cnt_d = '0;
            state_d     = S_RST;
          end
        end

        default: begin
          // S_FAIL: park here until restart.
          cnt_d = '0;
        end
      endcase
    end
  end

  // All state, the synchronizer and the registered outputs. The outputs are
  // decoded from state_d so that each output flop always matches state_q.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_meta_q  <= 1'b0;
      rdy_s_q     <= 1'b0;
      state_q     <= S_RST;
      cnt_q       <= '0;
      retry_cnt_q <= '0;
      rdy_lost_q  <= 1'b0;
      idc_rst_q   <= 1'b1;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      rdy_meta_q  <= rdy;
      rdy_s_q     <= rdy_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_cnt_q <= retry_cnt_d;
      rdy_lost_q  <= rdy_lost_d;
      idc_rst_q   <= (state_d == S_RST);
      busy_q      <= (state_d == S_RST) || (state_d == S_WAIT);
      ready_q     <= (state_d == S_READY);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign idc_rst   = idc_rst_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign fail      = fail_q;
  assign rdy_lost  = rdy_lost_q;
  assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_idelay_ctrl_seq.sv
// tb_idelay_ctrl_seq
// Self-checking bench for idelay_ctrl_seq with RST_CYCLES=8, TIMEOUT_CYCLES=32
// and MAX_RETRIES=2. When a scenario is driven, its expected results go into a
// scoreboard queue. Each result is popped and compared once the DUT produces
// the matching observation.
module tb_idelay_ctrl_seq;

  localparam int RC = 8;
  localparam int TC = 32;
  localparam int MR = 2;

  logic       refclk  = 1'b0;
  logic       rst_n   = 1'b0;
  logic       restart = 1'b0;
  logic       rdy     = 1'b0;
  logic       idc_rst;
  logic       ready;
  logic       busy;
  logic       fail;
  logic       rdy_lost;
  logic [1:0] retry_cnt;

  idelay_ctrl_seq #(
    .RST_CYCLES    (RC),
    .TIMEOUT_CYCLES(TC),
    .MAX_RETRIES   (MR),
    .CNT_WIDTH     (16),
    .RETRY_WIDTH   (2)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .restart  (restart),
    .rdy      (rdy),
    .idc_rst  (idc_rst),
    .ready    (ready),
    .busy     (busy),
    .fail     (fail),
    .rdy_lost (rdy_lost),
    .retry_cnt(retry_cnt)
  );

  always #5 refclk = ~refclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic observe(input string tag, input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_no_expect"}, obs, 32'hFFFF_FFFF);
    end else begin
      e = sb_q.pop_front();
      if (e.tag != tag) $display("note: scoreboard order %s vs %s", e.tag, tag);
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic expect_outs(input string p, input int e_idc, input int e_busy,
                             input int e_ready, input int e_fail, input int e_lost,
                             input int e_retry);
    expect_val({p, "_idc_rst"}, e_idc);
    expect_val({p, "_busy"}, e_busy);
    expect_val({p, "_ready"}, e_ready);
    expect_val({p, "_fail"}, e_fail);
    expect_val({p, "_rdy_lost"}, e_lost);
    expect_val({p, "_retry_cnt"}, e_retry);
    observe({p, "_idc_rst"}, 32'(idc_rst));
    observe({p, "_busy"}, 32'(busy));
    observe({p, "_ready"}, 32'(ready));
    observe({p, "_fail"}, 32'(fail));
    observe({p, "_rdy_lost"}, 32'(rdy_lost));
    observe({p, "_retry_cnt"}, 32'(retry_cnt));
  endtask

  // One active edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  // Length of the idc_rst high phase, counted from the current sample.
  task automatic idc_len(output int n);
    n = 0;
    while (idc_rst && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int prev;
    int rises;
    int rise_cyc[4];
    int lost_cnt, lost_at, ready_at, idc_at, retry_at, idc_hi;

    // ---------------- reset values ----------------
    rst_n = 1'b0;
    repeat (3) tick();
    expect_outs("reset", 1, 1, 0, 0, 0, 0);

    // ---------------- nominal ----------------
    expect_val("nom_idc_len", RC);
    rst_n = 1'b1;
    idc_len(n);
    observe("nom_idc_len", n);
    repeat (5) tick();
    rdy = 1'b1;
    expect_val("nom_rdy_latency", 3);
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    observe("nom_rdy_latency", n);
    expect_outs("nom_ready", 0, 0, 1, 0, 0, 0);

    // ---------------- restart coinciding with RDY drop ----------------
    rdy = 1'b0;
    tick();
    tick();
    expect_val("drop_pending_ready", 1);
    observe("drop_pending_ready", 32'(ready));
    restart = 1'b1;
    tick();
    restart = 1'b0;
    expect_outs("restart_vs_drop", 1, 1, 0, 0, 0, 0);

    // ---------------- retry ----------------
    expect_val("retry_rises", 3);
    expect_val("retry_gap1", RC + TC);
    expect_val("retry_gap2", RC + TC);
    prev        = 1;
    rises       = 1;
    rise_cyc[0] = cyc;
    n           = 0;
    while (!ready && n < 400) begin
      tick();
      n++;
      if (idc_rst && prev == 0 && rises < 4) begin
        rise_cyc[rises] = cyc;
        rises++;
      end
      if (!idc_rst && prev == 1 && rises == 3) rdy = 1'b1;
      prev = int'(idc_rst);
    end
    observe("retry_rises", rises);
    observe("retry_gap1", rise_cyc[1] - rise_cyc[0]);
    observe("retry_gap2", rise_cyc[2] - rise_cyc[1]);
    expect_outs("retry_done", 0, 0, 1, 0, 0, MR);

    // ---------------- lost RDY ----------------
    expect_val("lost_pulses", 1);
    expect_val("lost_edge", 2);
    expect_val("lost_ready", 0);
    expect_val("lost_idc_rst", 1);
    expect_val("lost_retry_cnt", 0);
    expect_val("lost_idc_len", RC);
    expect_val("lost_recovered", 1);
    lost_cnt = 0; lost_at = -1; ready_at = -1; idc_at = -1; retry_at = -1; idc_hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0)  rdy = 1'b0;
      if (i == 10) rdy = 1'b1;
      tick();
      if (idc_rst) idc_hi++;
      if (rdy_lost) begin
        lost_cnt++;
        lost_at  = i;
        ready_at = int'(ready);
        idc_at   = int'(idc_rst);
        retry_at = int'(retry_cnt);
      end
    end
    observe("lost_pulses", lost_cnt);
    observe("lost_edge", lost_at);
    observe("lost_ready", ready_at);
    observe("lost_idc_rst", idc_at);
    observe("lost_retry_cnt", retry_at);
    observe("lost_idc_len", idc_hi);
    observe("lost_recovered", 32'(ready));

    // ---------------- fail / restart ----------------
    rdy   = 1'b0;
    rst_n = 1'b0;
    tick();
    expect_val("fail_cycle", (MR + 1) * (RC + TC));
    rst_n = 1'b1;
    n = 0;
    while (!fail && n < 300) begin
      tick();
      n++;
    end
    observe("fail_cycle", n);
    expect_outs("fail_state", 0, 0, 0, 1, 0, MR);
    repeat (5) tick();
    expect_val("fail_sticky", 1);
    observe("fail_sticky", 32'(fail));
    restart = 1'b1;
    tick();
    restart = 1'b0;
    expect_outs("fail_restart", 1, 1, 0, 0, 0, 0);

    // ---------------- stale RDY through RST ----------------
    rdy = 1'b1;
    expect_val("stale_idc_len", RC);
    expect_val("stale_rst_ready", 0);
    expect_val("stale_wait_ticks", 4);
    n = 0;
    prev = 0;
    while (idc_rst && n < 100) begin
      if (ready) prev = 1;
      tick();
      n++;
    end
    observe("stale_idc_len", n);
    observe("stale_rst_ready", prev);
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    observe("stale_wait_ticks", n);

    // ---------------- reset mid-WAIT ----------------
    rdy     = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n = 0;
    while (!(retry_cnt == 2'd1 && !idc_rst) && n < 200) begin
      tick();
      n++;
    end
    repeat (10) tick();
    expect_val("midwait_busy", 1);
    expect_val("midwait_retry", 1);
    observe("midwait_busy", 32'(busy && !idc_rst));
    observe("midwait_retry", 32'(retry_cnt));
    rst_n = 1'b0;
    #1;
    expect_outs("midwait_async_rst", 1, 1, 0, 0, 0, 0);
    tick();
    expect_val("midwait_rerun_len", RC);
    rst_n = 1'b1;
    idc_len(n);
    observe("midwait_rerun_len", n);
    rdy = 1'b1;
    expect_val("midwait_rerun_ticks", 4);
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    observe("midwait_rerun_ticks", n);
    expect_outs("midwait_final", 0, 0, 1, 0, 0, 0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/idelay_ctrl_seq.md
# idelay_ctrl_seq

Bring-up sequencer that drives the reset input of an IDELAYCTRL instance and supervises its RDY output. Runs in the IDELAYCTRL reference-clock domain. Generates a minimum-width calibration reset, waits for RDY with a timeout, retries a bounded number of times, and reports ready/fail status to the memory-interface control logic. Re-runs the sequence when RDY is lost or on software request.

## Interface
- `RST_CYCLES`, 64: refclk cycles `idc_rst` is held high per attempt; must be ≥ 1.
- `TIMEOUT_CYCLES`, 4096: refclk cycles allowed in WAIT for RDY before an attempt fails; must be ≥ 4.
- `MAX_RETRIES`, 3: extra attempts after the first before FAIL.
- `CNT_WIDTH`, 16: width of the shared cycle counter; must hold `max(RST_CYCLES, TIMEOUT_CYCLES)`.
- `RETRY_WIDTH`, 2: width of `retry_cnt`; must hold `MAX_RETRIES`.

Ports:
- `refclk` in 1: the single clock (IDELAYCTRL reference clock).
- `rst_n` in 1: asynchronous, active-low reset.
- `restart` in 1: single-cycle request to re-run calibration from any state.
- `rdy` in 1: RDY from IDELAYCTRL, treated as asynchronous.
- `idc_rst` out 1: reset to IDELAYCTRL, active high.
- `ready` out 1: calibration complete and RDY currently held.
- `busy` out 1: in RST or WAIT.
- `fail` out 1: retries exhausted; sticky until `restart` or `rst_n`.
- `rdy_lost` out 1: one-cycle pulse when RDY drops while READY.
- `retry_cnt` out RETRY_WIDTH: retries consumed in the current sequence.

## Operation
- `rdy` passes through a 2-flop synchronizer to give `rdy_s`. All decisions use `rdy_s`.
- The state machine has four states: RST, WAIT, READY, FAIL. One shared counter `cnt`.
- **Reset values** (while `rst_n`=0): state RST, `cnt`=0, `idc_rst`=1, `busy`=1, `ready`=0, `fail`=0, `rdy_lost`=0, `retry_cnt`=0, sync flops 0.
- **RST:** `idc_rst`=1. `cnt` increments each cycle. When `cnt`==RST_CYCLES-1, go to WAIT and set `cnt`=0.
- **WAIT:** `idc_rst`=0 and `cnt` increments.
  - If `cnt`≥3 and `rdy_s`=1, go to READY. The `cnt`≥3 condition masks stale RDY still in the synchronizer.
  - Otherwise, when `cnt`==TIMEOUT_CYCLES-1:
    - if `retry_cnt`<MAX_RETRIES, increment `retry_cnt` and go to RST with `cnt`=0;
    - else go to FAIL.
- **READY:** `ready`=1.
  - If `rdy_s`=0, pulse `rdy_lost` for 1 cycle, clear `retry_cnt`, and go to RST with `cnt`=0.
- **FAIL:** `fail`=1 and `idc_rst`=0. The block stays in FAIL until `restart`.
- **restart** has priority over every other transition in every state. It forces RST with `cnt`=0 and `retry_cnt`=0, and clears `fail`. If `restart` and an RDY drop coincide in READY, `rdy_lost` is not pulsed.
- All outputs are registered. `ready` = (state==READY), `busy` = (state∈{RST,WAIT}), `fail` = (state==FAIL), `idc_rst` = (state==RST).
- `retry_cnt` saturates at MAX_RETRIES and never wraps.

## Timing
- After `rst_n` deasserts, `idc_rst` stays high through edge RST_CYCLES.
  - It is high during reset and for RST_CYCLES clock edges after deassertion.
  - It is low after the edge at which `cnt`==RST_CYCLES-1 is processed.
- Minimum RDY latency: `rdy` high at edge k (with WAIT `cnt`≥3 satisfied) gives `rdy_s` high after edge k+1 and `ready`=1 after edge k+2.
  - Worst case is 3 edges from the asynchronous `rdy` edge.
- Timeout: with no RDY, WAIT lasts exactly TIMEOUT_CYCLES cycles.
  - Attempt period is RST_CYCLES+TIMEOUT_CYCLES cycles.
  - FAIL is reached (MAX_RETRIES+1)×(RST_CYCLES+TIMEOUT_CYCLES) cycles after reset release.
- RDY loss: `rdy` low gives `rdy_lost` and `idc_rst` high 3 edges later, in the same cycle. `ready` drops in that same cycle.
- `restart` at edge k gives `idc_rst`=1 and `busy`=1 after edge k. `restart` during RST restarts the full RST_CYCLES count.
- Asserting `rst_n` mid-operation immediately forces the reset values asynchronously.

## Test plan
Bench parameters: RST_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- **Nominal:** release `rst_n`, model RDY high 5 cycles after `idc_rst` falls. Required: `idc_rst` high for 8 cycles; `ready`=1 within 3 cycles of RDY; `retry_cnt`=0; `fail`=0.
- **Retry:** RDY held low on attempts 1–2, high on attempt 3. Required: `idc_rst` pulses 3 times, 40 cycles apart; `retry_cnt`=2; `ready`=1; `fail`=0.
- **Fail/restart:** RDY held low. Required: `fail`=1 at cycle 120, `idc_rst`=0, `busy`=0. Then pulse `restart`. Required: `fail`=0, `idc_rst`=1 next cycle, `retry_cnt`=0.
- **Lost RDY:** in READY, drop RDY for 10 cycles. Required: one `rdy_lost` pulse, `ready`=0, new 8-cycle `idc_rst`, `retry_cnt`=0.
- **Stale RDY:** keep RDY high through the whole RST phase. Required: no transition to READY before WAIT `cnt`=3.
- **Reset mid-WAIT:** assert `rst_n`=0 at WAIT `cnt`=10. Required: outputs take reset values immediately; the sequence restarts on release.
